// File: rtl/subleq_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// subleq_mem_arbiter_if
// Request/acknowledge bus between one requester (CPU datapath or host port)
// and the SUBLEQ memory arbiter.
//   req    requester -> arbiter  level request, held until ack
//   we     requester -> arbiter  1 = write, 0 = read; stable while req
//   addr   requester -> arbiter  word address; stable while req
//   wdata  requester -> arbiter  write data; stable while req
//   ack    arbiter -> requester  one-cycle completion strobe
//   rdata  arbiter -> requester  read data, valid only while ack = 1
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface subleq_mem_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
);
    logic                 req;
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic                 ack;
    logic [DATA_BITS-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/subleq_mem_arbiter.sv
// -----------------------------------------------------------------------------
// subleq_mem_arbiter
// Shares the single-port synchronous SUBLEQ main memory between the CPU
// datapath and the host port. Round-robin arbitration, one access in flight,
// registered memory-side outputs.
// Ports:
//   clk        system clock, rising edge
//   areset_n   asynchronous reset, active low
//   cpu_if     CPU requester bus (slave side)
//   host_if    host requester bus (slave side)
//   mem_en     memory enable (registered)
//   mem_we     memory write enable (registered)
//   mem_addr   memory word address (registered, holds while mem_en = 0)
//   mem_wdata  memory write data (registered, holds while mem_en = 0)
//   mem_rdata  memory read data, valid the cycle after mem_en
// -----------------------------------------------------------------------------
module subleq_mem_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
) (
    input  logic                  clk,
    input  logic                  areset_n,
    subleq_mem_arbiter_if.slave   cpu_if,
    subleq_mem_arbiter_if.slave   host_if,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_BITS-1:0]  mem_wdata,
    input  logic [DATA_BITS-1:0]  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE_CPU  = 3'd1,
        ISSUE_HOST = 3'd2,
        RESP_CPU   = 3'd3,
        RESP_HOST  = 3'd4
    } state_t;

    // Priority token: which port wins a simultaneous request.
    localparam logic PRIO_CPU  = 1'b0;
    localparam logic PRIO_HOST = 1'b1;

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic                 grant_cpu, grant_host;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= IDLE;
            prio_q      <= PRIO_CPU;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_cpu   = 1'b0;
        grant_host  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_if.req && (!host_if.req || prio_q == PRIO_CPU)) begin
                    grant_cpu = 1'b1;
                end else if (host_if.req) begin
                    grant_host = 1'b1;
                end
            end
            ISSUE_CPU: begin
                state_d  = RESP_CPU;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
            ISSUE_HOST: begin
                state_d  = RESP_HOST;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
            // The port being acked drops or renews req at this edge, so only
            // the other port can be granted here; a renewed request is picked
            // up from IDLE, which is what keeps the other port from starving.
            RESP_CPU: begin
                if (host_if.req) grant_host = 1'b1;
                else             state_d    = IDLE;
            end
            RESP_HOST: begin
                if (cpu_if.req) grant_cpu = 1'b1;
                else            state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A grant loads the memory-side registers and hands priority over.
        if (grant_cpu) begin
            state_d     = ISSUE_CPU;
            prio_d      = PRIO_HOST;
            mem_en_d    = 1'b1;
            mem_we_d    = cpu_if.we;
            mem_addr_d  = cpu_if.addr;
            mem_wdata_d = cpu_if.wdata;
        end else if (grant_host) begin
            state_d     = ISSUE_HOST;
            prio_d      = PRIO_CPU;
            mem_en_d    = 1'b1;
            mem_we_d    = host_if.we;
            mem_addr_d  = host_if.addr;
            mem_wdata_d = host_if.wdata;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Read data passes straight through during the response cycle only.
    assign cpu_if.ack    = (state_q == RESP_CPU);
    assign host_if.ack   = (state_q == RESP_HOST);
    assign cpu_if.rdata  = (state_q == RESP_CPU)  ? mem_rdata : '0;
    assign host_if.rdata = (state_q == RESP_HOST) ? mem_rdata : '0;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
module tb_subleq_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } op_t;

    typedef struct packed {
        logic        we;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;

    subleq_mem_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(16)) cpu_bus ();
    subleq_mem_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(16)) host_bus ();

    subleq_mem_arbiter #(.ADDR_BITS(16), .DATA_BITS(16)) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .cpu_if    (cpu_bus.slave),
        .host_if   (host_bus.slave),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Port 0 = CPU, port 1 = host.
    logic        req_s [2];
    logic        we_s  [2];
    logic [15:0] addr_s[2];
    logic [15:0] wdata_s[2];
    logic        ack_s [2];
    logic [15:0] rdata_s[2];

    assign cpu_bus.req    = req_s[0];
    assign cpu_bus.we     = we_s[0];
    assign cpu_bus.addr   = addr_s[0];
    assign cpu_bus.wdata  = wdata_s[0];
    assign host_bus.req   = req_s[1];
    assign host_bus.we    = we_s[1];
    assign host_bus.addr  = addr_s[1];
    assign host_bus.wdata = wdata_s[1];
    assign ack_s[0]   = cpu_bus.ack;
    assign rdata_s[0] = cpu_bus.rdata;
    assign ack_s[1]   = host_bus.ack;
    assign rdata_s[1] = host_bus.rdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    op_t  op_q [2][$];
    exp_t exp_q[2][$];
    logic busy [2];
    int   issue_cyc[2];
    int   last_lat [2];
    int   ack_cnt  [2];
    int   mem_we_cnt = 0;
    int   port_log[$];
    int   cyc_log [$];

    logic [15:0] mem_arr   [0:65535];
    logic [15:0] shadow    [0:65535];

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous memory: read-before-write, data next cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem_arr[mem_addr];
            if (mem_we) mem_arr[mem_addr] = mem_wdata;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_op(input int p, input logic we, input logic [15:0] a, input logic [15:0] d);
        op_t op;
        op.we = we; op.addr = a; op.wdata = d;
        op_q[p].push_back(op);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((op_q[0].size() != 0 || op_q[1].size() != 0 || busy[0] || busy[1]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            tests++; fails++;
            $display("FAIL drain: requests still pending after %0d cycles", n);
        end
        @(negedge clk);
    endtask

    // Requester drivers: hold req until ack, then renew with the next queued
    // op at the following edge or drop req.
    for (genvar gi = 0; gi < 2; gi++) begin : g_drv
        initial begin
            op_t  op;
            exp_t ex;
            int   n;
            req_s[gi] = 1'b0; we_s[gi] = 1'b0; addr_s[gi] = 16'h0; wdata_s[gi] = 16'h0;
            busy[gi] = 1'b0; last_lat[gi] = 0; issue_cyc[gi] = 0;
            forever begin
                @(posedge clk);
                #1;
                if (op_q[gi].size() != 0) begin
                    op = op_q[gi].pop_front();
                    busy[gi]    = 1'b1;
                    req_s[gi]   = 1'b1;
                    we_s[gi]    = op.we;
                    addr_s[gi]  = op.addr;
                    wdata_s[gi] = op.wdata;
                    issue_cyc[gi] = cyc;
                    ex.we   = op.we;
                    ex.data = shadow[op.addr];
                    if (op.we) shadow[op.addr] = op.wdata;
                    exp_q[gi].push_back(ex);
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!ack_s[gi] && n < 40);
                    if (!ack_s[gi]) begin
                        tests++; fails++;
                        $display("FAIL ack_timeout port %0d: no ack after %0d cycles", gi, n);
                    end
                    last_lat[gi] = cyc - issue_cyc[gi];
                    busy[gi] = 1'b0;
                end else begin
                    req_s[gi] = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    logic prev_req[2] = '{1'b0, 1'b0};
    logic prev_ack[2] = '{1'b0, 1'b0};
    string pname[2] = '{"cpu", "host"};

    always @(negedge clk) begin
        exp_t ex;
        if (mem_we) mem_we_cnt++;
        if (ack_s[0] && ack_s[1]) chk("both_acks", 1, 0);
        for (int p = 0; p < 2; p++) begin
            if (areset_n && prev_req[p] && !prev_ack[p] && !req_s[p])
                chk("req_rule", 0, 1);
            if (ack_s[p]) begin
                ack_cnt[p]++;
                port_log.push_back(p);
                cyc_log.push_back(cyc);
                if (exp_q[p].size() == 0) begin
                    chk("unexpected_ack", p, -1);
                end else begin
                    ex = exp_q[p].pop_front();
                    $display("[TB] cycle %0d %s ack %s rdata=0x%04h", cyc, pname[p],
                             ex.we ? "write" : "read", rdata_s[p]);
                    if (!ex.we) chk({pname[p], "_rdata"}, int'(rdata_s[p]), int'(ex.data));
                end
            end else begin
                chk({pname[p], "_rdata_idle"}, int'(rdata_s[p]), 0);
            end
            prev_req[p] = req_s[p];
            prev_ack[p] = ack_s[p];
        end
    end

    initial begin
        int base, n;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        for (int i = 0; i < 65536; i++) begin
            mem_arr[i] = 16'h0;
            shadow[i]  = 16'h0;
        end
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 16'(i * 3 + 1);
            shadow[i]  = 16'(i * 3 + 1);
        end
        mem_arr[16'h0010] = 16'h0005; shadow[16'h0010] = 16'h0005;
        mem_arr[16'h0030] = 16'hBEEF; shadow[16'h0030] = 16'hBEEF;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_cpu_ack", int'(ack_s[0]), 0);
        chk("rst_host_ack", int'(ack_s[1]), 0);
        areset_n = 1'b1;

        // Both request right after reset: CPU first (lat 2), host next (lat 4).
        port_log.delete(); cyc_log.delete();
        push_op(0, 1'b0, 16'h0040, 16'h0);
        push_op(1, 1'b0, 16'h0041, 16'h0);
        wait_idle();
        chk("t2_first_cpu", port_log[0], 0);
        chk("t2_then_host", port_log[1], 1);
        chk("t2_cpu_lat", last_lat[0], 2);
        chk("t2_host_lat", last_lat[1], 4);

        // CPU-only access leaves prio with host; simultaneous -> host wins.
        push_op(0, 1'b0, 16'h0042, 16'h0);
        wait_idle();
        port_log.delete(); cyc_log.delete();
        push_op(0, 1'b0, 16'h0043, 16'h0);
        push_op(1, 1'b0, 16'h0044, 16'h0);
        wait_idle();
        chk("t2b_host_wins", port_log[0], 1);
        chk("t2b_then_cpu", port_log[1], 0);

        // Isolated CPU read of 0x0010.
        push_op(0, 1'b0, 16'h0010, 16'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_en && n < 10);
        chk("t1_mem_en", int'(mem_en), 1);
        chk("t1_mem_en_delay", cyc - issue_cyc[0], 1);
        chk("t1_mem_we", int'(mem_we), 0);
        chk("t1_mem_addr", int'(mem_addr), 16'h0010);
        wait_idle();
        chk("t1_cpu_lat", last_lat[0], 2);

        // Host write then CPU read of the same word.
        base = mem_we_cnt; n = ack_cnt[1];
        push_op(1, 1'b1, 16'h0020, 16'h1234);
        wait_idle();
        chk("t3_mem_we_cycles", mem_we_cnt - base, 1);
        chk("t3_host_ack_pulses", ack_cnt[1] - n, 1);
        chk("t3_mem_written", int'(mem_arr[16'h0020]), 16'h1234);
        push_op(0, 1'b0, 16'h0020, 16'h0);
        wait_idle();

        // CPU-only back-to-back reads: ack every 3 cycles, host silent.
        port_log.delete(); cyc_log.delete();
        n = ack_cnt[1];
        for (int i = 0; i < 3; i++) push_op(0, 1'b0, 16'(16'h0050 + i), 16'h0);
        wait_idle();
        chk("t6_ack_count", port_log.size(), 3);
        for (int i = 1; i < 3; i++) chk("t6_period", cyc_log[i] - cyc_log[i-1], 3);
        chk("t6_host_silent", ack_cnt[1] - n, 0);

        // Continuous traffic on both ports: strict alternation, period 4.
        port_log.delete(); cyc_log.delete();
        for (int i = 0; i < 50; i++) begin
            push_op(0, 1'b0, 16'(16'h0060 + i), 16'h0);
            push_op(1, 1'b0, 16'(16'h00A0 + i), 16'h0);
        end
        wait_idle();
        chk("t4_ack_count", port_log.size(), 100);
        for (int i = 1; i < port_log.size(); i++) begin
            chk("t4_alternate", int'(port_log[i] != port_log[i-1]), 1);
            if (i >= 2) chk("t4_period", cyc_log[i] - cyc_log[i-2], 4);
        end

        // Reset during ISSUE_HOST; afterwards both pending, CPU first.
        push_op(1, 1'b0, 16'h0030, 16'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(mem_en && mem_addr == 16'h0030) && n < 10);
        chk("t5_issue_host", int'(mem_en), 1);
        push_op(0, 1'b0, 16'h0010, 16'h0);
        #2 areset_n = 1'b0;
        #1;
        chk("t5_mem_en", int'(mem_en), 0);
        chk("t5_mem_addr", int'(mem_addr), 0);
        chk("t5_cpu_ack", int'(ack_s[0]), 0);
        chk("t5_host_ack", int'(ack_s[1]), 0);
        chk("t5_host_rdata", int'(rdata_s[1]), 0);
        repeat (2) @(negedge clk);
        port_log.delete(); cyc_log.delete();
        areset_n = 1'b1;
        wait_idle();
        chk("t5_ack_count", port_log.size(), 2);
        if (port_log.size() >= 2) begin
            chk("t5_cpu_first", port_log[0], 0);
            chk("t5_host_second", port_log[1], 1);
        end

        repeat (3) @(negedge clk);
        chk("end_exp_cpu_empty", exp_q[0].size(), 0);
        chk("end_exp_host_empty", exp_q[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
